// File: rtl/synctimer_pkg.sv
// Shared types and helpers for the synctimer correction scheduler.
//   state_e       : scheduler state, 2-bit encoding visible on status_state
//   wide_err_t    : 64-bit signed working type for phase errors
//   sat_error     : clamp a wide signed error into a w-bit signed range
//   sat_magnitude : |e| of a w-bit saturated error, with |min| folded to max
// Error and timer widths must lie in 2..63 so the 64-bit working type never overflows.
package synctimer_pkg;

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StAcquire  = 2'd1,
    StTrack    = 2'd2,
    StHoldover = 2'd3
  } state_e;

  typedef logic signed [63:0] wide_err_t;

  function automatic wide_err_t sat_max(input int unsigned w);
    return (wide_err_t'(1) <<< (w - 1)) - wide_err_t'(1);
  endfunction

  function automatic wide_err_t sat_error(input wide_err_t e, input int unsigned w);
    wide_err_t hi;
    wide_err_t lo;
    hi = sat_max(w);
    lo = -hi - wide_err_t'(1);
    if (e > hi) return hi;
    if (e < lo) return lo;
    return e;
  endfunction

  function automatic logic [63:0] sat_magnitude(input wide_err_t e, input int unsigned w);
    wide_err_t hi;
    wide_err_t a;
    hi = sat_max(w);
    a  = (e < 0) ? -e : e;
    // The most negative value has no positive twin; report it as the max.
    if (a > hi) a = hi;
    return $unsigned(a);
  endfunction

endpackage

// File: rtl/synctimer_correct_error.sv
// Stage 1 of the correction scheduler: wrap-aware phase error of a master-time sample.
//   clk_i, rst_i     : clock, synchronous active-high reset
//   valid_i          : accepted sample strobe (already gated by the scheduler)
//   current_time_i   : local timer value
//   sync_time_i      : master time sample
//   valid_o          : valid_i delayed one cycle
//   time_o           : sync_time_i captured with the sample
//   error_o          : sync_time - current_time, modulo 2^TIMER_WIDTH, saturated to ERROR_WIDTH
//   mag_o            : saturated magnitude of error_o
module synctimer_correct_error
  import synctimer_pkg::*;
#(
  parameter int unsigned TIMER_WIDTH = 32,
  parameter int unsigned ERROR_WIDTH = 32
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          valid_i,
  input  logic [TIMER_WIDTH-1:0]        current_time_i,
  input  logic [TIMER_WIDTH-1:0]        sync_time_i,
  output logic                          valid_o,
  output logic [TIMER_WIDTH-1:0]        time_o,
  output logic signed [ERROR_WIDTH-1:0] error_o,
  output logic [ERROR_WIDTH-1:0]        mag_o
);

  logic                          valid_q, valid_d;
  logic [TIMER_WIDTH-1:0]        time_q, time_d;
  logic signed [ERROR_WIDTH-1:0] error_q, error_d;
  logic [ERROR_WIDTH-1:0]        mag_q, mag_d;

  logic [TIMER_WIDTH-1:0]        diff;
  logic signed [TIMER_WIDTH-1:0] diff_s;
  wide_err_t                     diff_w;
  wide_err_t                     sat_w;

  always_comb begin
    // Unsigned subtract wraps naturally; reinterpret as signed for shortest-path error.
    diff    = sync_time_i - current_time_i;
    diff_s  = $signed(diff);
    diff_w  = wide_err_t'(diff_s);
    sat_w   = sat_error(diff_w, ERROR_WIDTH);
    valid_d = valid_i;
    time_d  = time_q;
    error_d = error_q;
    mag_d   = mag_q;
    if (valid_i) begin
      time_d  = sync_time_i;
      error_d = ERROR_WIDTH'(sat_w);
      mag_d   = ERROR_WIDTH'(sat_magnitude(sat_w, ERROR_WIDTH));
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      time_q  <= '0;
      error_q <= '0;
      mag_q   <= '0;
    end else begin
      valid_q <= valid_d;
      time_q  <= time_d;
      error_q <= error_d;
      mag_q   <= mag_d;
    end
  end

  assign valid_o = valid_q;
  assign time_o  = time_q;
  assign error_o = error_q;
  assign mag_o   = mag_q;

endmodule

// File: rtl/synctimer_correct_scheduler.sv
// Correction scheduler for the synctimer adjuster. Turns raw master-time samples into
// renew/track corrections with fixed latency 2, and tracks acquire/track/holdover state,
// lock qualification and a sample-loss timeout.
//   clk, rst                 : clock, synchronous active-high reset
//   enable                   : 0 forces IDLE and flushes the pipeline
//   param_renew_threshold    : |error| above this forces a renew
//   param_lock_threshold     : |error| at/below this counts toward lock
//   param_lock_count         : consecutive good samples for lock (0 treated as 1)
//   param_timeout            : cycles without a decision before HOLDOVER (0 disables)
//   current_time, sync_time  : local timer and master sample
//   sync_valid               : one-cycle sample strobe
//   correct_renew/time/valid : correction interface to the adjuster
//   status_state/locked/error: state, lock indication, last decided signed error
module synctimer_correct_scheduler
  import synctimer_pkg::*;
#(
  parameter int unsigned TIMER_WIDTH      = 32,
  parameter int unsigned ERROR_WIDTH      = 32,
  parameter int unsigned LOCK_COUNT_WIDTH = 8,
  parameter int unsigned TIMEOUT_WIDTH    = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic [ERROR_WIDTH-1:0]        param_renew_threshold,
  input  logic [ERROR_WIDTH-1:0]        param_lock_threshold,
  input  logic [LOCK_COUNT_WIDTH-1:0]   param_lock_count,
  input  logic [TIMEOUT_WIDTH-1:0]      param_timeout,
  input  logic [TIMER_WIDTH-1:0]        current_time,
  input  logic [TIMER_WIDTH-1:0]        sync_time,
  input  logic                          sync_valid,
  output logic                          correct_renew,
  output logic [TIMER_WIDTH-1:0]        correct_time,
  output logic                          correct_valid,
  output logic [1:0]                    status_state,
  output logic                          status_locked,
  output logic signed [ERROR_WIDTH-1:0] status_error
);

  state_e                        state_q, state_d;
  logic [LOCK_COUNT_WIDTH-1:0]   lock_cnt_q, lock_cnt_d;
  logic                          locked_q, locked_d;
  logic [TIMEOUT_WIDTH-1:0]      timeout_cnt_q, timeout_cnt_d;
  logic                          renew_q, renew_d;
  logic                          valid_q, valid_d;
  logic [TIMER_WIDTH-1:0]        time_q, time_d;
  logic signed [ERROR_WIDTH-1:0] error_q, error_d;

  logic                          sample_ok;
  logic                          s1_valid;
  logic [TIMER_WIDTH-1:0]        s1_time;
  logic signed [ERROR_WIDTH-1:0] s1_error;
  logic [ERROR_WIDTH-1:0]        s1_mag;

  logic                          decision;
  logic                          expiry;
  logic [TIMEOUT_WIDTH-1:0]      timeout_inc;
  logic [LOCK_COUNT_WIDTH-1:0]   lock_cnt_inc;
  logic [LOCK_COUNT_WIDTH-1:0]   lock_target;

  // Samples are only accepted once out of IDLE, which drops any sample on the enable-rise cycle.
  assign sample_ok = sync_valid & enable & (state_q != StIdle);

  synctimer_correct_error #(
    .TIMER_WIDTH (TIMER_WIDTH),
    .ERROR_WIDTH (ERROR_WIDTH)
  ) u_error (
    .clk_i          (clk),
    .rst_i          (rst),
    .valid_i        (sample_ok),
    .current_time_i (current_time),
    .sync_time_i    (sync_time),
    .valid_o        (s1_valid),
    .time_o         (s1_time),
    .error_o        (s1_error),
    .mag_o          (s1_mag)
  );

  assign decision     = s1_valid & enable;
  assign timeout_inc  = (timeout_cnt_q == '1) ? timeout_cnt_q
                                              : timeout_cnt_q + TIMEOUT_WIDTH'(1);
  assign lock_cnt_inc = (lock_cnt_q == '1) ? lock_cnt_q : lock_cnt_q + LOCK_COUNT_WIDTH'(1);
  assign lock_target  = (param_lock_count == '0) ? LOCK_COUNT_WIDTH'(1) : param_lock_count;
  // Expiry is aligned so the state flips on the cycle the counter shows param_timeout;
  // a decision in the same cycle takes precedence.
  assign expiry       = (state_q == StTrack) && (param_timeout != '0) &&
                        (timeout_inc == param_timeout) && !decision;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle:                state_d = StAcquire;
        StAcquire, StHoldover: if (decision) state_d = StTrack;
        StTrack:               if (expiry) state_d = StHoldover;
        default:               state_d = StIdle;
      endcase
    end
  end

  // Decision, lock and timeout logic.
  always_comb begin
    lock_cnt_d    = lock_cnt_q;
    locked_d      = locked_q;
    timeout_cnt_d = timeout_inc;
    renew_d       = 1'b0;
    valid_d       = 1'b0;
    time_d        = time_q;
    error_d       = error_q;
    if (!enable) begin
      lock_cnt_d    = '0;
      locked_d      = 1'b0;
      timeout_cnt_d = '0;
    end else if (decision) begin
      valid_d       = 1'b1;
      time_d        = s1_time;
      error_d       = s1_error;
      timeout_cnt_d = '0;
      if (state_q == StAcquire) begin
        renew_d    = 1'b1;
        lock_cnt_d = '0;
        locked_d   = 1'b0;
      end else if (s1_mag > param_renew_threshold) begin
        renew_d    = 1'b1;
        lock_cnt_d = '0;
        locked_d   = 1'b0;
      end else if (s1_mag <= param_lock_threshold) begin
        lock_cnt_d = lock_cnt_inc;
        locked_d   = (lock_cnt_inc >= lock_target);
      end else begin
        lock_cnt_d = '0;
        locked_d   = 1'b0;
      end
    end else if (expiry) begin
      locked_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lock_cnt_q    <= '0;
      locked_q      <= 1'b0;
      timeout_cnt_q <= '0;
      renew_q       <= 1'b0;
      valid_q       <= 1'b0;
      time_q        <= '0;
      error_q       <= '0;
    end else begin
      lock_cnt_q    <= lock_cnt_d;
      locked_q      <= locked_d;
      timeout_cnt_q <= timeout_cnt_d;
      renew_q       <= renew_d;
      valid_q       <= valid_d;
      time_q        <= time_d;
      error_q       <= error_d;
    end
  end

  assign correct_renew = renew_q;
  assign correct_time  = time_q;
  assign correct_valid = valid_q;
  assign status_state  = state_q;
  assign status_locked = locked_q;
  assign status_error  = error_q;

endmodule
